// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and burst helpers, used by the arbiter and by the AHB master.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam int BEAT_W = 5;

    // Undefined-length INCR reports 1 so that len-1 loads an idle counter.
    function automatic logic [BEAT_W-1:0] burst_len(input logic [2:0] hburst);
        logic [BEAT_W-1:0] len;
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   len = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin priority encoder: first requester strictly after ptr wins,
// wrapping so the master at ptr itself is considered last.
module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          ptr,
    output logic [NUM_MASTERS-1:0] winner,
    output logic                   valid
);

    logic [MW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = MW'((int'(ptr) + i) % NUM_MASTERS);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB-Lite round-robin bus arbiter with burst-aware arbitration points.
// Optional locked-transfer support is enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic                   HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [BEAT_W-1:0]      beat_cnt;
    logic [MW-1:0]          rr_ptr;
    logic [MW-1:0]          grant_idx;
    logic [MW-1:0]          pick_idx;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] next_grant;
    logic [MW-1:0]          next_idx;
    logic                   last_beat;
    logic                   open_drop;
    logic                   arb_cond;
    logic                   owner_lock;
    logic                   arb;

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_picker (
        .req    (HBUSREQ),
        .ptr    (rr_ptr),
        .winner (pick_grant),
        .valid  (pick_valid)
    );

    always_comb begin
        grant_idx = '0;
        pick_idx  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i])     grant_idx = MW'(i);
            if (pick_grant[i]) pick_idx  = MW'(i);
        end
    end

`ifdef AHB_ARB_LOCK_EN
    assign owner_lock = HLOCK[HMASTER];
`else
    logic unused_hlock;
    assign unused_hlock = ^HLOCK;
    assign owner_lock   = 1'b0;
`endif

    // The owner is the master currently driving the address phase (HMASTER).
    always_comb begin
        last_beat = (HBURST != HBURST_INCR) &&
                    (((HTRANS == HTRANS_SEQ) && (beat_cnt == 5'd1)) ||
                     ((HTRANS == HTRANS_NONSEQ) && (HBURST == HBURST_SINGLE)));
        open_drop = (HBURST == HBURST_INCR) && !HBUSREQ[HMASTER];
        arb_cond  = (HTRANS != HTRANS_BUSY) &&
                    ((HTRANS == HTRANS_IDLE) || last_beat || open_drop);
        arb       = HREADY && (HRESP || (arb_cond && !owner_lock));
        next_grant = pick_valid ? pick_grant : DEF_GRANT;
        next_idx   = pick_valid ? pick_idx : DEF_IDX;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANT   <= DEF_GRANT;
            HMASTER  <= DEF_IDX;
            rr_ptr   <= DEF_IDX;
            beat_cnt <= '0;
        end else if (HREADY) begin
            case (HTRANS)
                HTRANS_NONSEQ: beat_cnt <= burst_len(HBURST) - 5'd1;
                HTRANS_SEQ:    if (beat_cnt != '0) beat_cnt <= beat_cnt - 5'd1;
                default:       beat_cnt <= beat_cnt;
            endcase
            // Address phase follows the grant one HREADY edge later.
            HMASTER <= grant_idx;
            if (arb) begin
                HGRANT <= next_grant;
                rr_ptr <= next_idx;
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic mastlock_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mastlock_q <= 1'b0;
        end else if (HREADY) begin
            mastlock_q <= HLOCK[grant_idx];
        end
    end
    assign HMASTLOCK = mastlock_q;
`else
    assign HMASTLOCK = 1'b0;
`endif

endmodule
